// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator for the decode stage.
// Decodes the immediate, format and legality of each accepted instruction into a
// 2-entry FIFO; the head entry drives the outputs. Counts accepted illegal opcodes.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid,
   output logic             oReady,
   input  logic [31:0]      iInstrucao,
   input  logic             iFlush,
   output logic             oValid,
   input  logic             iReady,
   output logic [XLEN-1:0]  oImm,
   output logic [2:0]       oFmt,
   output logic             oIllegal,
   output logic [CNT_W-1:0] oIllegalCount
);

   localparam logic [6:0] OpcLoad     = 7'b0000011;
   localparam logic [6:0] OpcMiscMem  = 7'b0001111;
   localparam logic [6:0] OpcOpImm    = 7'b0010011;
   localparam logic [6:0] OpcAuipc    = 7'b0010111;
   localparam logic [6:0] OpcOpImm32  = 7'b0011011;
   localparam logic [6:0] OpcStore    = 7'b0100011;
   localparam logic [6:0] OpcOp       = 7'b0110011;
   localparam logic [6:0] OpcLui      = 7'b0110111;
   localparam logic [6:0] OpcOp32     = 7'b0111011;
   localparam logic [6:0] OpcBranch   = 7'b1100011;
   localparam logic [6:0] OpcJalr     = 7'b1100111;
   localparam logic [6:0] OpcJal      = 7'b1101111;
   localparam logic [6:0] OpcSystem   = 7'b1110011;

   localparam logic [2:0] FmtNone = 3'd0;
   localparam logic [2:0] FmtI    = 3'd1;
   localparam logic [2:0] FmtS    = 3'd2;
   localparam logic [2:0] FmtB    = 3'd3;
   localparam logic [2:0] FmtU    = 3'd4;
   localparam logic [2:0] FmtJ    = 3'd5;
   localparam logic [2:0] FmtZ    = 3'd6;

   localparam bit Rv64 = (XLEN == 64);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
   } entry_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   entry_t     dec;

   entry_t          ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]      occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            accept, pop;

   assign opcode = iInstrucao[6:0];
   assign funct3 = iInstrucao[14:12];

   // Combinational decode of the incoming instruction word.
   always_comb begin
      dec.imm = '0;
      dec.fmt = FmtNone;
      dec.ill = 1'b0;
      case (opcode)
         OpcLoad, OpcOpImm, OpcJalr: begin
            dec.fmt = FmtI;
            dec.imm = XLEN'($signed(iInstrucao[31:20]));
         end
         OpcOpImm32: begin
            if (Rv64) begin
               dec.fmt = FmtI;
               dec.imm = XLEN'($signed(iInstrucao[31:20]));
            end else begin
               dec.ill = 1'b1;
            end
         end
         OpcStore: begin
            dec.fmt = FmtS;
            dec.imm = XLEN'($signed({iInstrucao[31:25], iInstrucao[11:7]}));
         end
         OpcBranch: begin
            dec.fmt = FmtB;
            dec.imm = XLEN'($signed({iInstrucao[31], iInstrucao[7], iInstrucao[30:25],
                                     iInstrucao[11:8], 1'b0}));
         end
         OpcLui, OpcAuipc: begin
            dec.fmt = FmtU;
            dec.imm = XLEN'($signed({iInstrucao[31:12], 12'b0}));
         end
         OpcJal: begin
            dec.fmt = FmtJ;
            dec.imm = XLEN'($signed({iInstrucao[31], iInstrucao[19:12], iInstrucao[20],
                                     iInstrucao[30:21], 1'b0}));
         end
         OpcSystem: begin
            if (funct3[2]) begin
               dec.fmt = FmtZ;
               dec.imm = XLEN'(iInstrucao[19:15]);
            end else if (funct3 != 3'b000) begin
               dec.fmt = FmtI;
               dec.imm = XLEN'($signed(iInstrucao[31:20]));
            end
         end
         OpcOp, OpcMiscMem: ;
         OpcOp32: dec.ill = !Rv64;
         default: dec.ill = 1'b1;
      endcase
   end

   // oReady comes from registered occupancy only, never from iReady.
   assign oReady   = (occ_q != 2'd2) && !iRST;
   assign oValid   = (occ_q != 2'd0);
   assign oImm     = ent0_q.imm;
   assign oFmt     = ent0_q.fmt;
   assign oIllegal = ent0_q.ill;
   assign oIllegalCount = cnt_q;

   assign accept = iValid && oReady;
   assign pop    = oValid && iReady;

   // FIFO next state; flush wins over push/pop and leaves stale data masked by oValid.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      if (iFlush) begin
         occ_d = 2'd0;
      end else begin
         case ({accept, pop})
            2'b10: begin
               if (occ_q == 2'd0) ent0_d = dec;
               else               ent1_d = dec;
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               ent0_d = ent1_q;
               occ_d  = occ_q - 2'd1;
            end
            // Accept implies occupancy below 2, pop implies non-empty: occupancy is 1.
            2'b11: ent0_d = dec;
            default: ;
         endcase
      end
   end

   // Saturating illegal-instruction counter; flushed instructions are not counted.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && dec.ill && !iFlush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
         cnt_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32, RV64, RV32 with 2-bit counter) share
// stimulus; a cycle model with an expected-entry queue checks every output each cycle.
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  fmt32;
      logic [2:0]  fmt64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   vec_t tv[16];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, valid, flush, rdy;
   logic [31:0] instr;
   int cur_idx;

   logic        rdy32, val32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [15:0] cnt32;
   logic        rdy64, val64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [15:0] cnt64;
   logic        rdys, vals, ills;
   logic [31:0] imms;
   logic [2:0]  fmts;
   logic [1:0]  cnts;

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
      .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(rdy32), .iInstrucao(instr),
      .iFlush(flush), .oValid(val32), .iReady(rdy), .oImm(imm32), .oFmt(fmt32),
      .oIllegal(ill32), .oIllegalCount(cnt32));

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
      .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(rdy64), .iInstrucao(instr),
      .iFlush(flush), .oValid(val64), .iReady(rdy), .oImm(imm64), .oFmt(fmt64),
      .oIllegal(ill64), .oIllegalCount(cnt64));

   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) usat (
      .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(rdys), .iInstrucao(instr),
      .iFlush(flush), .oValid(vals), .iReady(rdy), .oImm(imms), .oFmt(fmts),
      .oIllegal(ills), .oIllegalCount(cnts));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] ins, input logic [63:0] i32,
                          input logic [63:0] i64, input logic [2:0] f32, input logic [2:0] f64,
                          input logic l32, input logic l64);
      tv[i].instr = ins; tv[i].imm32 = i32; tv[i].imm64 = i64;
      tv[i].fmt32 = f32; tv[i].fmt64 = f64; tv[i].ill32 = l32; tv[i].ill64 = l64;
   endtask

   // Cycle model: expected FIFO contents as table indices, plus counters.
   int q[$];
   int m_cnt32, m_cnt64, m_cnts;
   bit clean, acc_flag;
   bit chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit push, popv;
      if (rst) begin
         q.delete();
         m_cnt32 = 0; m_cnt64 = 0; m_cnts = 0;
         clean = 1'b1; acc_flag = 1'b0;
      end else if (flush) begin
         q.delete();
         acc_flag = 1'b0;
      end else begin
         push = valid && (q.size() < 2);
         popv = (q.size() > 0) && rdy;
         if (popv) void'(q.pop_front());
         if (push) begin
            q.push_back(cur_idx);
            clean = 1'b0;
            if (tv[cur_idx].ill32) begin
               if (m_cnt32 < 65535) m_cnt32++;
               if (m_cnts < 3) m_cnts++;
            end
            if (tv[cur_idx].ill64 && m_cnt64 < 65535) m_cnt64++;
         end
         acc_flag = push;
      end
   end

   // Per-cycle comparison of all instances against the model, away from the edge.
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         bit ev, er;
         ev = q.size() > 0;
         er = (q.size() < 2) && !rst;
         chk("valid32", val32, ev);
         chk("valid64", val64, ev);
         chk("valid_sat", vals, ev);
         chk("ready32", rdy32, er);
         chk("ready64", rdy64, er);
         chk("ready_sat", rdys, er);
         chk("count32", cnt32, m_cnt32);
         chk("count64", cnt64, m_cnt64);
         chk("count_sat", cnts, m_cnts);
         if (ev) begin
            chk("imm32", imm32, tv[q[0]].imm32);
            chk("fmt32", fmt32, tv[q[0]].fmt32);
            chk("ill32", ill32, tv[q[0]].ill32);
            chk("imm64", imm64, tv[q[0]].imm64);
            chk("fmt64", fmt64, tv[q[0]].fmt64);
            chk("ill64", ill64, tv[q[0]].ill64);
         end else if (clean) begin
            chk("imm32_rst", imm32, 64'h0);
            chk("fmt32_rst", fmt32, 64'h0);
            chk("ill32_rst", ill32, 64'h0);
            chk("imm64_rst", imm64, 64'h0);
            chk("fmt64_rst", fmt64, 64'h0);
            chk("ill64_rst", ill64, 64'h0);
         end
      end
   end

   task automatic drive(input int idx, input bit v);
      cur_idx = idx;
      instr   = tv[idx].instr;
      valid   = v;
   endtask

   // Present one instruction until accepted (bounded), then drop iValid.
   task automatic push_wait(input int idx);
      bit got;
      got = 1'b0;
      drive(idx, 1'b1);
      for (int c = 0; c < 20 && !got; c++) begin
         @(posedge clk);
         #1;
         got = acc_flag;
      end
      if (!got) chk("accept_timeout", 64'h0, 64'h1);
      @(negedge clk);
      valid = 1'b0;
   endtask

   initial begin
      set_vec(0,  32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 0, 0);
      set_vec(1,  32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 0, 0);
      set_vec(2,  32'hFF9FF06F, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 3'd5, 0, 0);
      set_vec(3,  32'h3002D073, 64'h5,        64'h5,                3'd6, 3'd6, 0, 0);
      set_vec(4,  32'h00000073, 64'h0,        64'h0,                3'd0, 3'd0, 0, 0);
      set_vec(5,  32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 0, 0);
      set_vec(6,  32'h0010009B, 64'h0,        64'h1,                3'd0, 3'd1, 1, 0);
      set_vec(7,  32'h00000000, 64'h0,        64'h0,                3'd0, 3'd0, 1, 1);
      set_vec(8,  32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 0, 0);
      set_vec(9,  32'h00001017, 64'h1000,     64'h1000,             3'd4, 3'd4, 0, 0);
      set_vec(10, 32'h00208033, 64'h0,        64'h0,                3'd0, 3'd0, 0, 0);
      set_vec(11, 32'h0020803B, 64'h0,        64'h0,                3'd0, 3'd0, 1, 0);
      set_vec(12, 32'h30002073, 64'h300,      64'h300,              3'd1, 3'd1, 0, 0);
      set_vec(13, 32'h80002083, 64'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 0, 0);
      set_vec(14, 32'h0000000F, 64'h0,        64'h0,                3'd0, 3'd0, 0, 0);
      set_vec(15, 32'h00008067, 64'h0,        64'h0,                3'd1, 3'd1, 0, 0);

      rst = 1'b1; valid = 1'b0; flush = 1'b0; rdy = 1'b0; instr = '0; cur_idx = 0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Full table streamed back-to-back with the consumer always ready.
      rdy = 1'b1;
      for (int i = 0; i < 16; i++) push_wait(i);
      repeat (3) @(negedge clk);

      // Backpressure: two fill the buffer, the third is held until the consumer drains.
      rdy = 1'b0;
      drive(0, 1'b1);
      @(negedge clk) drive(1, 1'b1);
      @(negedge clk) drive(2, 1'b1);
      repeat (3) @(negedge clk);
      chk("bp_ready_low", rdy32, 64'h0);
      chk("bp_head_stable", imm32, tv[0].imm32);
      rdy = 1'b1;
      begin
         bit got;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            got = acc_flag;
         end
         if (!got) chk("bp_accept_timeout", 64'h0, 64'h1);
      end
      @(negedge clk) valid = 1'b0;
      repeat (4) @(negedge clk);

      // Illegal counting from a clean reset, including saturation of the 2-bit counter.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) push_wait(7);
      repeat (2) @(negedge clk);
      chk("illegal_cnt32", cnt32, 64'd5);
      chk("illegal_cnt64", cnt64, 64'd5);
      chk("illegal_cnt_sat", cnts, 64'd3);

      // Flush a full buffer with an illegal instruction presented in the same cycle.
      rdy = 1'b0;
      push_wait(0);
      push_wait(1);
      drive(7, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      valid = 1'b0;
      chk("flush_valid", val32, 64'h0);
      chk("flush_ready", rdy32, 64'h1);
      chk("flush_cnt_kept", cnt32, 64'd5);
      repeat (2) @(negedge clk);

      // Reset in the middle of a stream.
      rdy = 1'b1;
      push_wait(3);
      drive(4, 1'b1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", rdy32, 64'h0);
      chk("rst_valid", val32, 64'h0);
      chk("rst_imm", imm32, 64'h0);
      chk("rst_cnt", cnt32, 64'h0);
      rst = 1'b0;
      valid = 1'b0;
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
